// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection encodings and default widths.
package uart_pkg;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH    = 8;
  localparam int ERR_CNT_WIDTH = 8;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator for a UART data word; shared by the Tx parity
// generator and the Rx parity checker.
module parity_calc #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data_bits,
  input  logic                  par_type,
  output logic                  parity_bit_from_sent_data
);

  import uart_pkg::*;

  // Odd parity is the complement of the even (XOR-reduction) parity.
  assign parity_bit_from_sent_data = (^data_bits) ^ (par_type == PAR_ODD);

endmodule

// File: rtl/parity_check.sv
// UART Rx parity checker: registers a mismatch between the sampled parity bit
// and the parity of the received word. Optional saturating error counter under
// the PARITY_ERR_CNT_EN macro.
module parity_check #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
`ifdef PARITY_ERR_CNT_EN
  , parameter int ERR_CNT_WIDTH = uart_pkg::ERR_CNT_WIDTH
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     par_type,
  input  logic                     par_chk_en,
  input  logic                     parity_bit,
  input  logic [DATA_WIDTH-1:0]    data_bits,
  output logic                     parity_error
`ifdef PARITY_ERR_CNT_EN
  , output logic [ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

  // Expected parity; name kept stable for hierarchical probing.
  logic parity_bit_from_sent_data;
  logic chk_fail;

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data_bits                 (data_bits),
    .par_type                  (par_type),
    .parity_bit_from_sent_data (parity_bit_from_sent_data)
  );

  // Gating by the enable keeps the flag at 0 outside the sampling slot,
  // regardless of what the data lines carry.
  assign chk_fail = par_chk_en && (parity_bit != parity_bit_from_sent_data);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_error <= 1'b0;
    end else begin
      parity_error <= chk_fail;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Saturating count of reported errors; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (chk_fail && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_parity_check.sv
// Self-checking bench for parity_check: directed cases, exhaustive sweep and
// randomized traffic against a ones-counting reference model.
module tb_parity_check;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          par_type;
  logic          par_chk_en;
  logic          parity_bit;
  logic [DW-1:0] data_bits;
  logic          parity_error;
`ifdef PARITY_ERR_CNT_EN
  logic [CW-1:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  parity_check #(
    .DATA_WIDTH (DW)
`ifdef PARITY_ERR_CNT_EN
    , .ERR_CNT_WIDTH (CW)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .par_type     (par_type),
    .par_chk_en   (par_chk_en),
    .parity_bit   (parity_bit),
    .data_bits    (data_bits),
    .parity_error (parity_error)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt    (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: parity bit that makes the total ones count even (or odd).
  function automatic logic ref_parity(input logic [DW-1:0] d, input logic odd);
    int ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ odd;
  endfunction

  // Drive inputs away from the active edge and probe the combinational net.
  task automatic apply(input logic en, input logic t, input logic [DW-1:0] d, input logic p);
    @(negedge clk);
    par_chk_en = en;
    par_type   = t;
    data_bits  = d;
    parity_bit = p;
    #1;
    check("calc_net", dut.parity_bit_from_sent_data, ref_parity(d, t));
  endtask

  // One active edge; compare registered outputs with the model.
  task automatic step();
    logic exp_err;
    exp_err = rst && par_chk_en && (parity_bit != ref_parity(data_bits, par_type));
    if (exp_err && exp_cnt < (1 << CW) - 1) exp_cnt++;
    @(posedge clk);
    #1;
    check("parity_error", parity_error, exp_err);
`ifdef PARITY_ERR_CNT_EN
    check("err_cnt", err_cnt, exp_cnt);
`endif
  endtask

  initial begin
    // Reset with an enabled, erroneous-looking input must hold the flag low.
    rst        = 1'b0;
    par_chk_en = 1'b1;
    par_type   = 1'($urandom);
    data_bits  = DW'($urandom);
    parity_bit = 1'($urandom);
    #3;
    check("reset_flag", parity_error, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("reset_cnt", err_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    par_chk_en = 1'b0;

    // Odd parity mismatch.
    apply(1'b1, 1'b1, 8'b1000_1010, 1'b1);
    check("odd_expected_bit", dut.parity_bit_from_sent_data, 1'b0);
    step();
    check("odd_mismatch", parity_error, 1'b1);

    // Even parity match.
    apply(1'b1, 1'b0, 8'b1000_1010, 1'b1);
    check("even_expected_bit", dut.parity_bit_from_sent_data, 1'b1);
    step();
    check("even_match", parity_error, 1'b0);

    // Enable gating: one-cycle error pulse only while strobed.
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check("gate_low", parity_error, 1'b0);
    apply(1'b1, 1'b0, 8'h00, 1'b1);
    step();
    check("gate_pulse", parity_error, 1'b1);
    apply(1'b0, 1'b0, 8'h00, 1'b1);
    step();
    check("gate_pulse_end", parity_error, 1'b0);

    // Exhaustive sweep with one-cycle strobes.
    for (int d = 0; d < 256; d++) begin
      for (int t = 0; t < 2; t++) begin
        for (int p = 0; p < 2; p++) begin
          apply(1'b1, 1'(t), 8'(d), 1'(p));
          step();
          apply(1'b0, 1'(t), 8'(d), 1'(p));
          step();
        end
      end
    end

    // Random traffic, including held enables and changes while disabled.
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom), 1'($urandom), DW'($urandom), 1'($urandom));
      step();
    end

    // Async reset in the middle of a check discards it immediately.
    apply(1'b1, 1'b1, 8'b1000_1010, 1'b1);
    step();
    check("pre_reset_err", parity_error, 1'b1);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    check("midcheck_reset", parity_error, 1'b0);
`ifdef PARITY_ERR_CNT_EN
    check("midcheck_reset_cnt", err_cnt, 0);
`endif
    apply(1'b1, 1'b1, 8'b1000_1010, 1'b1);
    step();
    @(negedge clk);
    rst = 1'b1;
    par_chk_en = 1'b0;

`ifdef PARITY_ERR_CNT_EN
    // Saturation: 300 consecutive errors with enable held high.
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] d;
      logic          t;
      d = DW'($urandom);
      t = 1'($urandom);
      apply(1'b1, t, d, ~ref_parity(d, t));
      step();
    end
    check("cnt_saturated", err_cnt, 255);
    apply(1'b1, 1'b0, 8'h01, 1'b0);
    step();
    check("cnt_no_wrap", err_cnt, 255);
    #1;
    rst = 1'b0;
    exp_cnt = 0;
    #1;
    check("cnt_reset", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    apply(1'b1, 1'b0, 8'h01, 1'b0);
    step();
    check("cnt_restart", err_cnt, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_check.md
Name: parity_check

Overview:
- Parity checker for the UART receiver datapath.
- Computes the expected parity of the received data word (even or odd, as selected) and compares it with the parity bit sampled from the line.
- Flags a mismatch on a registered output.
- Driven by the Rx FSM, which asserts the check enable in the parity-bit sampling slot.

Parameters:
- DATA_WIDTH, 8, number of data bits covered by the parity.
- ERR_CNT_WIDTH, 8, width of the optional error counter (used only when the optional feature is compiled in).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- par_type  input  1  parity selection: 0 = even, 1 = odd.
- par_chk_en  input  1  check enable; when high, the comparison result is captured this cycle.
- parity_bit  input  1  parity bit received on the serial line.
- data_bits  input  DATA_WIDTH  received data word; must be stable while par_chk_en is high.
- parity_error  output  1  registered mismatch flag.
- err_cnt  output  ERR_CNT_WIDTH  error count; present only with PARITY_ERR_CNT_EN.

Behaviour:
- Internal combinational net parity_bit_from_sent_data is the expected parity. This exact name is kept because benches probe it hierarchically.
  - par_type=0 (even): XOR-reduction of data_bits.
  - par_type=1 (odd): inverted XOR-reduction of data_bits.
  - The net tracks its inputs with zero latency.
- Reset: rst low asynchronously forces parity_error=0 (and err_cnt=0 when present). Reset mid-check discards the check; no error is reported for it.
- On each rising clk edge with rst high:
  - par_chk_en=1: parity_error <= (parity_bit != parity_bit_from_sent_data).
  - par_chk_en=0: parity_error <= 0.
- Latency: 1 clock from par_chk_en sampled high to parity_error valid.
- parity_error is a 1-cycle pulse per strobe-cycle. If par_chk_en is held high for N cycles, parity_error re-evaluates every cycle against the current inputs.
- Changing par_type or data_bits while par_chk_en is low has no effect on the outputs.
- No X propagation: the output is 0 whenever enable is low, whatever the data.

Optional Feature:
- Macro: PARITY_ERR_CNT_EN.
- Defined:
  - err_cnt output exists.
  - Increments by 1 on every clock edge at which parity_error is loaded with 1.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- Undefined: err_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - constant PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - default DATA_WIDTH=8.
- One natural sub-module: parity_calc, a purely combinational block with inputs data_bits and par_type and output parity_bit_from_sent_data. It is reusable by the UART Tx parity generator.

Test Plan:
- Reset: rst=0 with random inputs and par_chk_en=1 -> parity_error=0 (and err_cnt=0) immediately, without waiting for a clock edge.
- Odd mismatch: par_type=1, data_bits=8'b10001010, parity_bit=1, par_chk_en=1, one clk edge -> parity_bit_from_sent_data=0, parity_error=1.
- Even match: par_type=0, data_bits=8'b10001010, parity_bit=1, par_chk_en=1 -> parity_bit_from_sent_data=1, parity_error=0.
- Enable gating: par_type=0, data_bits=8'h00, parity_bit=1, par_chk_en=0 -> parity_error stays 0; raise par_chk_en for one cycle -> parity_error=1 for exactly one cycle, then 0.
- Exhaustive sweep: all 256 data values × both par_type × both parity_bit values, each with a 1-cycle strobe -> parity_error equals the reference XOR model every time.
- With PARITY_ERR_CNT_EN: 300 consecutive error strobes at ERR_CNT_WIDTH=8 -> err_cnt saturates at 255 and does not wrap; a reset mid-sequence returns it to 0.
